// File: rtl/mdu_seq.sv
// Iterative RV64 M-extension sequencer: shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MDU_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module mdu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             is_32,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] N_HALF = CNT_W'(32);
    localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_HALF = {{(WIDTH-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_nxt;

    function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] v);
        return {{(WIDTH-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [WIDTH-1:0] zext32(input logic [WIDTH-1:0] v);
        return {{(WIDTH-32){1'b0}}, v[31:0]};
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // acc: product / partial remainder; opa: multiplicand / dividend shifting into quotient;
    // opb: multiplier / divisor magnitude
    logic [WIDTH-1:0] acc, opa, opb;
    logic [CNT_W-1:0] cnt;
    logic             is_mul, sel_rem, w32, q_neg, r_neg;

    logic                    op_onehot, accept, signed_op, is_div;
    logic                    a_neg, b_neg, div_zero, div_ovf, special;
    logic signed [WIDTH-1:0] a_act, b_act;
    logic [WIDTH-1:0]        a_mag, b_mag, min_act;
    logic [WIDTH:0]          rem_sh, rem_diff;
    logic [WIDTH-1:0]        prod_add, fix_sel, fix_val;

    always_comb begin
        op_onehot = (op != 5'd0) && ((op & (op - 5'd1)) == 5'd0);
        accept    = (state == IDLE) && in_valid && op_onehot && !flush;
        signed_op = op[1] | op[3];
        is_div    = |op[4:1];
        a_act     = is_32 ? (signed_op ? sext32(src1) : zext32(src1)) : src1;
        b_act     = is_32 ? (signed_op ? sext32(src2) : zext32(src2)) : src2;
        // W operands are already extended, so the top bit is the sign at the active width
        a_neg     = signed_op & a_act[WIDTH-1];
        b_neg     = signed_op & b_act[WIDTH-1];
        a_mag     = a_neg ? -a_act : a_act;
        b_mag     = b_neg ? -b_act : b_act;
        min_act   = is_32 ? MIN_HALF : MIN_FULL;
        div_zero  = (b_act == '0);
        div_ovf   = signed_op && (a_act == min_act) && (b_act == '1);
        special   = is_div && (div_zero || div_ovf);
    end

    always_comb begin
        rem_sh   = {acc, opa[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb};
        prod_add = opb[0] ? (acc + opa) : acc;
        if (is_mul) begin
            fix_sel = acc;
        end else if (sel_rem) begin
            fix_sel = cond_neg(acc, r_neg);
        end else begin
            fix_sel = cond_neg(opa, q_neg);
        end
        fix_val = w32 ? sext32(fix_sel) : fix_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nxt = FIXUP;
                    end
`ifdef MDU_EARLY_OUT_EN
                    else if (op[0] && (b_act == '0)) begin
                        state_nxt = FIXUP;
                    end
`endif
                    else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIXUP;
                end
`ifdef MDU_EARLY_OUT_EN
                if (is_mul && (opb[WIDTH-1:1] == '0)) begin
                    state_nxt = FIXUP;
                end
`endif
            end
            FIXUP: state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            cnt     <= '0;
            is_mul  <= 1'b0;
            sel_rem <= 1'b0;
            w32     <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                w32     <= is_32;
                is_mul  <= op[0];
                sel_rem <= op[3] | op[4];
                cnt     <= is_32 ? N_HALF : N_FULL;
                if (op[0]) begin
                    acc   <= '0;
                    opa   <= a_act;
                    opb   <= b_act;
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end else if (special) begin
                    // final quotient/remainder preloaded; FIXUP only selects and extends
                    acc   <= div_zero ? a_act : '0;
                    opa   <= div_zero ? '1 : a_act;
                    opb   <= b_act;
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end else begin
                    acc   <= '0;
                    opa   <= is_32 ? (a_mag << 32) : a_mag;
                    opb   <= b_mag;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                end
            end else if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
                if (is_mul) begin
                    acc <= prod_add;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                end else if (!rem_diff[WIDTH]) begin
                    acc <= rem_diff[WIDTH-1:0];
                    opa <= {opa[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= rem_sh[WIDTH-1:0];
                    opa <= {opa[WIDTH-2:0], 1'b0};
                end
            end
            if ((state == FIXUP) && !flush) begin
                result <= fix_val;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE) && !flush;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus randomized ops against an arithmetic reference model.
module tb_mdu_seq;
    logic        clk, rst, flush, in_valid, in_ready, is_32, out_valid, out_ready, busy;
    logic [4:0]  op;
    logic [63:0] src1, src2, result;
    int          checks = 0;
    int          errors = 0;

    mdu_seq #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_32(is_32), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [4:0] o, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        int              sa, sb, rs;
        int unsigned     ua, ub;
        longint          la, lb, lr;
        longint unsigned lua, lub;
        logic [63:0]     r;
        if (w) begin
            sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
            if (o[0]) rs = sa * sb;
            else if (o[1]) begin
                if (sb == 0) rs = -1;
                else if (sa == int'(32'h8000_0000) && sb == -1) rs = sa;
                else rs = sa / sb;
            end else if (o[2]) begin
                if (ub == 0) rs = -1; else rs = int'(ua / ub);
            end else if (o[3]) begin
                if (sb == 0) rs = sa;
                else if (sa == int'(32'h8000_0000) && sb == -1) rs = 0;
                else rs = sa % sb;
            end else begin
                if (ub == 0) rs = int'(ua); else rs = int'(ua % ub);
            end
            r = {{32{rs[31]}}, rs};
        end else begin
            la = a; lb = b; lua = a; lub = b;
            if (o[0]) lr = la * lb;
            else if (o[1]) begin
                if (lb == 0) lr = -1;
                else if (la == longint'(64'h8000_0000_0000_0000) && lb == -1) lr = la;
                else lr = la / lb;
            end else if (o[2]) begin
                if (lub == 0) lr = -1; else lr = longint'(lua / lub);
            end else if (o[3]) begin
                if (lb == 0) lr = la;
                else if (la == longint'(64'h8000_0000_0000_0000) && lb == -1) lr = 0;
                else lr = la % lb;
            end else begin
                if (lub == 0) lr = longint'(lua); else lr = longint'(lua % lub);
            end
            r = lr;
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic [63:0] bb;
        bb = w ? {32'h0, b[31:0]} : b;
        if (o[0]) begin
`ifdef MDU_EARLY_OUT_EN
            if (bb == 0) return 2;
            for (int i = 63; i >= 0; i--) if (bb[i]) return i + 3;
`endif
            return w ? 34 : 66;
        end
        if (bb == 0) return 2;
        if ((o[1] | o[3]) && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
            return 2;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'h0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'($urandom_range(1, 40));
            4: v = {$urandom, $urandom};
            5: v = 64'hFFFF_FFFF_8000_0000;
            6: v = -64'($urandom_range(1, 40));
            default: v = {32'h0, $urandom};
        endcase
        return v;
    endfunction

    // Called just after a negedge; returns at the negedge of cycle 1 with inputs scrambled.
    task automatic start_op(input logic [4:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1; op = o; is_32 = w; src1 = a; src2 = b;
        check("in_ready_at_offer", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'b00001 << $urandom_range(0, 4);
        is_32 = 1'($urandom_range(0, 1));
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc = 1;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && cyc < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input logic [4:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input int hold, output logic [63:0] got, output int lat);
        logic [63:0] exp_r;
        int          exp_l, cyc;
        bit          bok, sok;
        exp_r = model_res(o, w, a, b);
        exp_l = model_lat(o, w, a, b);
        start_op(o, w, a, b);
        wait_done(cyc, bok);
        check("latency", 64'(cyc), 64'(exp_l));
        check("result", result, exp_r);
        check("busy_in_flight", {63'h0, bok}, 64'd1);
        got = result;
        lat = cyc;
        if (hold > 0) begin
            sok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (result !== got || out_valid !== 1'b1 || in_ready !== 1'b0) sok = 1'b0;
            end
            check("backpressure_hold", {63'h0, sok}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_handshake", {61'h0, in_ready, out_valid, busy}, 64'd4);
        check("result_kept", result, exp_r);
    endtask

    initial begin
        logic [63:0] got, prev;
        int          lat, cyc, exp_lat;
        bit          bok, nv;
        logic [4:0]  ro;

        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; op = 5'b00001; is_32 = 1'b0; src1 = 64'd7; src2 = 64'd6;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {61'h0, in_ready, out_valid, busy}, 64'd4);
        check("reset_result", result, 64'h0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        do_op(5'b00001, 1'b0, 64'd7, 64'd6, 0, got, lat);
        check("mul_7x6", got, 64'd42);
`ifdef MDU_EARLY_OUT_EN
        exp_lat = 5;
`else
        exp_lat = 66;
`endif
        check("mul_7x6_lat", 64'(lat), 64'(exp_lat));

        do_op(5'b00001, 1'b1, 64'h7FFF_FFFF, 64'd2, 0, got, lat);
        check("mulw_sext", got, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(5'b01000, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, got, lat);
        check("remw_neg", got, 64'hFFFF_FFFF_FFFF_FFFF);
        check("remw_lat", 64'(lat), 64'd34);
        do_op(5'b00010, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, got, lat);
        check("div_neg", got, 64'hFFFF_FFFF_FFFF_FFFA);

        do_op(5'b00100, 1'b0, 64'h1234, 64'h0, 0, got, lat);
        check("divu_by0", got, 64'hFFFF_FFFF_FFFF_FFFF);
        check("divu_by0_lat", 64'(lat), 64'd2);
        do_op(5'b10000, 1'b0, 64'h1234, 64'h0, 0, got, lat);
        check("remu_by0", got, 64'h1234);
        do_op(5'b00010, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, got, lat);
        check("div_ovf", got, 64'h8000_0000_0000_0000);
        check("div_ovf_lat", 64'(lat), 64'd2);
        do_op(5'b00010, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, got, lat);
        check("divw_ovf", got, 64'hFFFF_FFFF_8000_0000);

        // backpressure then back-to-back accept in the cycle after the handshake
        do_op(5'b00100, 1'b0, 64'd100, 64'd7, 10, got, lat);
        do_op(5'b10000, 1'b0, 64'd100, 64'd7, 0, got, lat);
        check("b2b_remu", got, 64'd2);

        do_op(5'b00001, 1'b0, 64'd5, 64'd1, 0, got, lat);
        check("mul_5x1", got, 64'd5);
`ifdef MDU_EARLY_OUT_EN
        exp_lat = 3;
`else
        exp_lat = 66;
`endif
        check("mul_5x1_lat", 64'(lat), 64'(exp_lat));
        do_op(5'b00001, 1'b0, 64'd9, 64'd0, 0, got, lat);
        check("mul_x0", got, 64'd0);
`ifdef MDU_EARLY_OUT_EN
        exp_lat = 2;
`else
        exp_lat = 66;
`endif
        check("mul_x0_lat", 64'(lat), 64'(exp_lat));

        in_valid = 1'b1; op = 5'b00000; src1 = 64'd3; src2 = 64'd3;
        @(posedge clk); @(negedge clk);
        check("no_accept_op0", {61'h0, in_ready, out_valid, busy}, 64'd4);
        op = 5'b00011;
        @(posedge clk); @(negedge clk);
        check("no_accept_op_multi", {61'h0, in_ready, out_valid, busy}, 64'd4);
        in_valid = 1'b0;

        prev = result;
        start_op(5'b00100, 1'b0, {$urandom, $urandom}, 64'd13);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check("flush_calc_idle", {61'h0, in_ready, out_valid, busy}, 64'd4);
        nv = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (out_valid !== 1'b0) nv = 1'b0;
        end
        check("flush_no_valid", {63'h0, nv}, 64'd1);
        check("flush_result_kept", result, prev);

        in_valid = 1'b1; op = 5'b00001; is_32 = 1'b0; src1 = 64'd3; src2 = 64'd3; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_accept_dropped", {61'h0, in_ready, out_valid, busy}, 64'd4);

        start_op(5'b00100, 1'b0, 64'h55, 64'h0);
        wait_done(cyc, bok);
        check("done_flush_lat", 64'(cyc), 64'd2);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("done_flush_no_hs", {63'h0, out_valid & out_ready}, 64'd0);
        @(posedge clk); @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("done_flush_idle", {61'h0, in_ready, out_valid, busy}, 64'd4);

        start_op(5'b00010, 1'b0, {$urandom, $urandom}, 64'd5);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ctrl", {61'h0, in_ready, out_valid, busy}, 64'd4);
        check("async_rst_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            ro = 5'b00001 << $urandom_range(0, 4);
            do_op(ro, 1'($urandom_range(0, 1)), pick(), pick(), 0, got, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
